// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - scan-code-set-2 constants, poll FSM encoding and byte-action codes
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  typedef enum logic [2:0] {
    ST_GAP  = 3'b001,
    ST_REQ  = 3'b010,
    ST_WAIT = 3'b100
  } poll_state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_BAD,
    ACT_SKIP,
    ACT_PAUSE,
    ACT_EXT,
    ACT_BRK,
    ACT_OVERRUN,
    ACT_PUSH
  } byte_act_t;

  // Device replies that carry no key information.
  function automatic logic is_ctrl_reply(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) || (b == SC_RESEND);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - key-event FIFO with wrap-bit pointers and combinational head
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clock_quarter,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] head_data,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid = !empty;
  assign pop   = valid && pop_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // Head reads as zero when empty so ev_* are clean after reset.
  assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock_quarter) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock_quarter) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - polls the PS/2 byte receiver and decodes set-2 prefixes into key events
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int POLL_GAP   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int E1_SKIP    = 7
) (
  input  logic       clock_quarter,
  input  logic       reset,
  input  logic       rx_ready,
  input  logic       rx_finish,
  input  logic       rx_faild,
  input  logic [7:0] rx_data,
  output logic       rx_start,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       overflow,
  output logic [7:0] err_cnt
);

  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam int SKIP_W = $clog2(E1_SKIP + 1);

  poll_state_t       state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [SKIP_W-1:0] skip_cnt;
  logic              bad_byte;
  logic              ext;
  logic              brk;
  byte_act_t         act;
  logic              push;
  logic [9:0]        head_data;
  logic              fifo_drop;

  // Classify the byte completing this cycle; timeouts carry no byte.
  always_comb begin
    act = ACT_NONE;
    if (state == ST_WAIT && rx_finish && !rx_faild) begin
      if (bad_byte)                             act = ACT_BAD;
      else if (skip_cnt != '0)                  act = ACT_SKIP;
      else if (rx_data == SC_PAUSE)             act = ACT_PAUSE;
      else if (rx_data == SC_EXT)               act = ACT_EXT;
      else if (rx_data == SC_BRK)               act = ACT_BRK;
      else if (rx_data == 8'h00 || rx_data == 8'hFF) act = ACT_OVERRUN;
      else if (is_ctrl_reply(rx_data))          act = ACT_NONE;
      else                                      act = ACT_PUSH;
    end
  end

  assign push = (act == ACT_PUSH);

  ps2_evt_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_quarter (clock_quarter),
    .reset         (reset),
    .push          (push),
    .push_data     ({ext, brk, rx_data}),
    .pop_ready     (ev_ready),
    .valid         (ev_valid),
    .head_data     (head_data),
    .drop          (fifo_drop)
  );

  assign ev_ext  = head_data[9];
  assign ev_brk  = head_data[8];
  assign ev_code = head_data[7:0];

  always_ff @(posedge clock_quarter) begin
    if (reset) begin
      state    <= ST_GAP;
      gap_cnt  <= '0;
      rx_start <= 1'b0;
      bad_byte <= 1'b0;
      skip_cnt <= '0;
      ext      <= 1'b0;
      brk      <= 1'b0;
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (fifo_drop) overflow <= 1'b1;

      case (state)
        ST_GAP: begin
          if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
            state    <= ST_REQ;
            rx_start <= 1'b1;
            gap_cnt  <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_REQ: begin
          if (!rx_ready) begin
            state    <= ST_WAIT;
            rx_start <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (rx_finish) begin
            state    <= ST_GAP;
            gap_cnt  <= '0;
            bad_byte <= 1'b0;
          end else if (rx_faild) begin
            bad_byte <= 1'b1;
          end
        end
        default: begin
          state    <= ST_GAP;
          gap_cnt  <= '0;
          rx_start <= 1'b0;
        end
      endcase

      case (act)
        ACT_BAD: begin
          ext      <= 1'b0;
          brk      <= 1'b0;
          skip_cnt <= '0;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
        ACT_SKIP:  skip_cnt <= skip_cnt - SKIP_W'(1);
        ACT_PAUSE: skip_cnt <= SKIP_W'(E1_SKIP);
        ACT_EXT:   ext <= 1'b1;
        ACT_BRK:   brk <= 1'b1;
        ACT_OVERRUN: begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
        ACT_PUSH: begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
